// File: rtl/channel_round_robin_scheduler.sv
// channel_round_robin_scheduler: round-robin flash-channel grant; drives choose_channel one cycle
// ahead of a one-cycle update_flag, then holds the grant until ch_done or watchdog expiry.
module channel_round_robin_scheduler #(
  parameter int NUM_CH  = 8,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              ch_done,
  output logic [3:0]        choose_channel,
  output logic              update_flag,
  output logic              sched_busy,
  output logic              timeout_err
);
  typedef enum logic [2:0] {IDLE, ARB, SETUP, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [3:0] last_grant, lo_idx, hi_idx, winner;
  logic hi_any, expire;
  logic [TO_W-1:0] wd;
  // Lowest request above last_grant wins; otherwise wrap to the lowest request overall.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) lo_idx = 4'(i);
      if (ch_req[i] && i > int'(last_grant)) begin
        hi_idx = 4'(i);
        hi_any = 1'b1;
      end
    end
  end
  assign winner = hi_any ? hi_idx : lo_idx;
  assign expire = state == WAIT && wd == TO_W'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable && |ch_req ? ARB : IDLE;
      ARB:     state_nx = |ch_req ? SETUP : IDLE;
      SETUP:   state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = ch_done || expire ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      choose_channel <= '0;
      update_flag    <= 1'b0;
      sched_busy     <= 1'b0;
      timeout_err    <= 1'b0;
      last_grant     <= 4'(NUM_CH - 1);
      wd             <= '0;
    end else begin
      state       <= state_nx;
      update_flag <= state_nx == ISSUE;
      sched_busy  <= state_nx != IDLE;
      timeout_err <= expire && !ch_done;
      wd          <= state == WAIT ? wd + 1'b1 : '0;
      if (state == ARB && |ch_req) choose_channel <= winner;
      if (state == WAIT && state_nx == IDLE) last_grant <= choose_channel;
    end
  end
endmodule

// File: tb/tb_channel_round_robin_scheduler.sv
// tb_channel_round_robin_scheduler: directed and random grants checked against a round-robin reference model.
module tb_channel_round_robin_scheduler;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, ch_done = 1'b0;
  logic [7:0] ch_req = '0;
  logic [3:0] choose_channel;
  logic update_flag, sched_busy, timeout_err;
  int checks = 0, failures = 0;
  int last_g = 7, cur_ch = 0;

  channel_round_robin_scheduler #(.NUM_CH(8), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_req(ch_req), .ch_done(ch_done),
    .choose_channel(choose_channel), .update_flag(update_flag),
    .sched_busy(sched_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_grant(input logic [7:0] req);
    for (int d = 1; d <= 8; d++) if (req[(last_g + d) % 8]) return (last_g + d) % 8;
    return -1;
  endfunction

  // One full grant from IDLE; done arrives after dly WAIT cycles (dly >= TIMEOUT means never).
  task automatic run_grant(input logic [7:0] req, input int dly, input bit drop_req, input bit drop_en);
    int g, n;
    bit to;
    g = exp_grant(req);
    to = dly >= TIMEOUT;
    ch_req = req;
    enable = 1'b1;
    tick;
    check("arb_busy", sched_busy, 1);
    check("arb_ch_held", choose_channel, cur_ch);
    check("arb_tmo", timeout_err, 0);
    if (drop_en) enable = 1'b0;
    tick;
    check("setup_ch", choose_channel, g);
    check("setup_flag", update_flag, 0);
    if (drop_req) ch_req = '0;
    tick;
    check("issue_flag", update_flag, 1);
    check("issue_ch", choose_channel, g);
    tick;
    check("wait_flag", update_flag, 0);
    n = 0;
    while (sched_busy && n < 40) begin
      check("wait_noflag", update_flag, 0);
      check("wait_notmo", timeout_err, 0);
      ch_done = n == dly;
      tick;
      ch_done = 1'b0;
      n++;
    end
    check("wait_len", n, to ? TIMEOUT : dly + 1);
    check("tmo_err", timeout_err, to);
    check("hold_ch", choose_channel, g);
    last_g = g;
    cur_ch = g;
  endtask

  initial begin
    tick;
    tick;
    check("rst_ch", choose_channel, 0);
    check("rst_flag", update_flag, 0);
    check("rst_busy", sched_busy, 0);
    check("rst_tmo", timeout_err, 0);
    reset_n = 1'b1;
    tick;
    run_grant(8'hFF, 2, 0, 0);
    check("first_ch0", choose_channel, 0);
    // reset in the middle of the next grant's WAIT
    ch_req = 8'hFF;
    enable = 1'b1;
    repeat (5) tick;
    check("pre_rst_ch", choose_channel, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_ch", choose_channel, 0);
    check("midrst_busy", sched_busy, 0);
    tick;
    check("midrst_flag", update_flag, 0);
    check("midrst_tmo", timeout_err, 0);
    reset_n = 1'b1;
    ch_req = '0;
    last_g = 7;
    cur_ch = 0;
    tick;
    run_grant(8'hFF, 1, 0, 0);
    check("postrst_ch0", choose_channel, 0);
    run_grant(8'h08, 4, 0, 0);
    check("single_ch3", choose_channel, 3);
    run_grant(8'h80, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      run_grant(8'hFF, 3, 0, 0);
      check("rr_order", choose_channel, k % 8);
    end
    run_grant(8'h40, 1, 0, 0);
    run_grant(8'h41, 1, 0, 0);
    check("wrap_ch0", choose_channel, 0);
    run_grant(8'h41, 1, 0, 0);
    check("wrap_ch6", choose_channel, 6);
    run_grant(8'h01, 100, 0, 0);
    run_grant(8'h03, 2, 0, 0);
    check("after_tmo_ch1", choose_channel, 1);
    run_grant(8'hFF, TIMEOUT - 1, 0, 0);
    // ch_done while IDLE and disabled
    enable = 1'b0;
    ch_req = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      ch_done = k[0];
      tick;
      check("idle_busy", sched_busy, 0);
      check("idle_flag", update_flag, 0);
      check("idle_ch", choose_channel, cur_ch);
    end
    ch_done = 1'b0;
    // request vanishes during ARB
    ch_req = 8'h10;
    enable = 1'b1;
    tick;
    ch_req = '0;
    tick;
    check("arbdrop_busy", sched_busy, 0);
    check("arbdrop_ch", choose_channel, cur_ch);
    repeat (3) begin
      tick;
      check("arbdrop_flag", update_flag, 0);
    end
    for (int k = 0; k < 40; k++)
      run_grant(8'($urandom_range(1, 255)), $urandom_range(0, 20), 1'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
